flash_bist: RTL and testbench

Parametrised flash self-test sequencer, the successor to the single-byte button test. It drives the flash controller's read/write strobe interface to write and/or read back a LEN-word block starting at BASE_ADDR. Each block has a pattern derived from SEED. Results are reported as pass/fail, a saturating error count and a one-hot LED status. It sits between board buttons and the flash controller, and owns the controller's command inputs.

---
 rtl/flash_bist.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_flash_bist.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_bist.sv
// -----------------------------------------------------------------------------
// flash_bist - flash self-test sequencer
//
// Drives the flash controller's read/write strobe interface to write and/or
// read back a LEN-word block starting at BASE_ADDR. Word k carries the pattern
// (SEED + k) at address (BASE_ADDR + k), both wrapping at their widths.
// Results are reported as pass/fail, a saturating mismatch count, a sticky
// timeout flag and a one-hot LED status.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start, mode     start request (rising edge used) and test mode
//                   (00 write, 01 read-verify, 10 write then verify, 11 reserved)
//   ctl_read/write  one-cycle command strobes to the controller
//   ctl_addr/din    command address and write data, held outside ISSUE
//   ctl_dout/busy   controller read data and busy flag
//   busy, done      sequencer running / result being held
//   pass, timeout   result flags
//   err_count       read mismatches this run, saturating at 255
//   leds            one-hot status: 001 idle, 010 running, 100 holding result
//
// Optional feature (macro FLASH_BIST_FIRST_FAIL_EN):
//   adds first_fail_addr / first_fail_data, which capture the address and read
//   data of the first mismatch in a run and hold until the next start.
// -----------------------------------------------------------------------------
module flash_bist #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h01AA,
  parameter int                LEN         = 16,
  parameter logic [DATA_W-1:0] SEED        = 8'h55,
  parameter int                ACK_TIMEOUT = 15,
  parameter int                HOLD_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              ctl_read,
  output logic              ctl_write,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_din,
  input  logic [DATA_W-1:0] ctl_dout,
  input  logic              ctl_busy,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [7:0]        err_count,
  output logic [2:0]        leds
`ifdef FLASH_BIST_FIRST_FAIL_EN
  ,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_data
`endif
);

  // Counter widths, kept at least one bit so degenerate parameters still build.
  localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(LEN - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACK   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  typedef enum logic {
    PH_WRITE = 1'b0,
    PH_READ  = 1'b1
  } phase_t;

  // Expected data for word index idx.
  function automatic logic [DATA_W-1:0] pattern_data(input logic [ADDR_W-1:0] idx);
    return SEED + DATA_W'(idx);
  endfunction

  // Address of word index idx; wraps silently at the address width.
  function automatic logic [ADDR_W-1:0] pattern_addr(input logic [ADDR_W-1:0] idx);
    return BASE_ADDR + idx;
  endfunction

  state_t              state_r,    state_next_s;
  phase_t              phase_r,    phase_next_s;
  logic [1:0]          mode_r,     mode_next_s;
  logic [ADDR_W-1:0]   k_r,        k_next_s;
  logic [ACK_W-1:0]    ack_cnt_r,  ack_cnt_next_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_next_s;
  logic [DATA_W-1:0]   rdata_r,    rdata_next_s;
  logic [7:0]          err_r,      err_next_s;
  logic                timeout_r,  timeout_next_s;

  logic                start_sync_r;
  logic                start_prev_r;
  logic                start_edge_r;

  logic                ctl_read_r;
  logic                ctl_write_r;
  logic [ADDR_W-1:0]   ctl_addr_r;
  logic [DATA_W-1:0]   ctl_din_r;
  logic                busy_r;
  logic                done_r;
  logic                pass_r;
  logic [2:0]          leds_r;
  logic [2:0]          leds_next_s;
  logic                pass_next_s;

`ifdef FLASH_BIST_FIRST_FAIL_EN
  logic                ff_seen_r,  ff_seen_next_s;
  logic [ADDR_W-1:0]   ff_addr_r,  ff_addr_next_s;
  logic [DATA_W-1:0]   ff_data_r,  ff_data_next_s;
`endif

  // Register start and derive a one-cycle pulse on its rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_sync_r <= 1'b0;
      start_prev_r <= 1'b0;
      start_edge_r <= 1'b0;
    end else begin
      start_sync_r <= start;
      start_prev_r <= start_sync_r;
      start_edge_r <= start_sync_r & ~start_prev_r;
    end
  end

  // Next-state and datapath decode for the sequencer.
  always_comb begin
    state_next_s    = state_r;
    phase_next_s    = phase_r;
    mode_next_s     = mode_r;
    k_next_s        = k_r;
    ack_cnt_next_s  = ack_cnt_r;
    hold_cnt_next_s = hold_cnt_r;
    rdata_next_s    = rdata_r;
    err_next_s      = err_r;
    timeout_next_s  = timeout_r;
`ifdef FLASH_BIST_FIRST_FAIL_EN
    ff_seen_next_s  = ff_seen_r;
    ff_addr_next_s  = ff_addr_r;
    ff_data_next_s  = ff_data_r;
`endif

    case (state_r)
      ST_IDLE: begin
        // A start is only honoured when the controller is free and the mode
        // is meaningful; otherwise the edge is simply lost.
        if (start_edge_r && !ctl_busy && (mode != 2'b11)) begin
          mode_next_s    = mode;
          err_next_s     = 8'd0;
          timeout_next_s = 1'b0;
          k_next_s       = '0;
          if (mode == 2'b01) begin
            phase_next_s = PH_READ;
          end else begin
            phase_next_s = PH_WRITE;
          end
`ifdef FLASH_BIST_FIRST_FAIL_EN
          ff_seen_next_s = 1'b0;
          ff_addr_next_s = '0;
          ff_data_next_s = '0;
`endif
          state_next_s   = ST_ISSUE;
        end else begin
          state_next_s   = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        ack_cnt_next_s = '0;
        state_next_s   = ST_ACK;
      end

      ST_ACK: begin
        if (ctl_busy) begin
          state_next_s    = ST_WAIT;
        end else if (ack_cnt_r == ACK_LAST) begin
          // Controller never acknowledged: abort the run.
          timeout_next_s  = 1'b1;
          hold_cnt_next_s = '0;
          state_next_s    = ST_HOLD;
        end else begin
          ack_cnt_next_s  = ack_cnt_r + ACK_W'(1);
          state_next_s    = ST_ACK;
        end
      end

      ST_WAIT: begin
        if (!ctl_busy) begin
          if (phase_r == PH_READ) begin
            rdata_next_s = ctl_dout;
          end else begin
            rdata_next_s = rdata_r;
          end
          state_next_s   = ST_NEXT;
        end else begin
          state_next_s   = ST_WAIT;
        end
      end

      ST_NEXT: begin
        if ((phase_r == PH_READ) && (rdata_r != pattern_data(k_r))) begin
          if (err_r != 8'hFF) begin
            err_next_s = err_r + 8'd1;
          end else begin
            err_next_s = err_r;
          end
`ifdef FLASH_BIST_FIRST_FAIL_EN
          // ctl_addr still holds the address of the word being checked.
          if (!ff_seen_r) begin
            ff_seen_next_s = 1'b1;
            ff_addr_next_s = ctl_addr_r;
            ff_data_next_s = rdata_r;
          end else begin
            ff_seen_next_s = ff_seen_r;
          end
`endif
        end else begin
          err_next_s = err_r;
        end

        if (k_r != LAST_K) begin
          k_next_s        = k_r + ADDR_W'(1);
          state_next_s    = ST_ISSUE;
        end else if ((mode_r == 2'b10) && (phase_r == PH_WRITE)) begin
          phase_next_s    = PH_READ;
          k_next_s        = '0;
          state_next_s    = ST_ISSUE;
        end else begin
          hold_cnt_next_s = '0;
          state_next_s    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_next_s    = ST_IDLE;
        end else begin
          hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
          state_next_s    = ST_HOLD;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Status decode from the upcoming state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    leds_next_s = 3'b000;
    case (state_next_s)
      ST_IDLE: leds_next_s = 3'b001;
      ST_HOLD: leds_next_s = 3'b100;
      default: leds_next_s = 3'b010;
    endcase
    pass_next_s = (state_next_s == ST_HOLD) && (err_next_s == 8'd0) && !timeout_next_s;
  end

  // Sequencer state and run bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      phase_r    <= PH_WRITE;
      mode_r     <= 2'b00;
      k_r        <= '0;
      ack_cnt_r  <= '0;
      hold_cnt_r <= '0;
      rdata_r    <= '0;
      err_r      <= 8'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      phase_r    <= phase_next_s;
      mode_r     <= mode_next_s;
      k_r        <= k_next_s;
      ack_cnt_r  <= ack_cnt_next_s;
      hold_cnt_r <= hold_cnt_next_s;
      rdata_r    <= rdata_next_s;
      err_r      <= err_next_s;
      timeout_r  <= timeout_next_s;
    end
  end

  // Registered command and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_read_r  <= 1'b0;
      ctl_write_r <= 1'b0;
      ctl_addr_r  <= '0;
      ctl_din_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      leds_r      <= 3'b000;
    end else begin
      ctl_read_r  <= (state_next_s == ST_ISSUE) && (phase_next_s == PH_READ);
      ctl_write_r <= (state_next_s == ST_ISSUE) && (phase_next_s == PH_WRITE);
      // Address and data only move when a command is about to be issued.
      if (state_next_s == ST_ISSUE) begin
        ctl_addr_r <= pattern_addr(k_next_s);
        ctl_din_r  <= pattern_data(k_next_s);
      end
      busy_r      <= (state_next_s != ST_IDLE);
      done_r      <= (state_next_s == ST_HOLD);
      pass_r      <= pass_next_s;
      leds_r      <= leds_next_s;
    end
  end

`ifdef FLASH_BIST_FIRST_FAIL_EN
  // First-mismatch capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_seen_r <= 1'b0;
      ff_addr_r <= '0;
      ff_data_r <= '0;
    end else begin
      ff_seen_r <= ff_seen_next_s;
      ff_addr_r <= ff_addr_next_s;
      ff_data_r <= ff_data_next_s;
    end
  end

  assign first_fail_addr = ff_addr_r;
  assign first_fail_data = ff_data_r;
`endif

  assign ctl_read  = ctl_read_r;
  assign ctl_write = ctl_write_r;
  assign ctl_addr  = ctl_addr_r;
  assign ctl_din   = ctl_din_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign timeout   = timeout_r;
  assign err_count = err_r;
  assign leds      = leds_r;

endmodule

// File: tb/tb_flash_bist.sv
// -----------------------------------------------------------------------------
// tb_flash_bist - directed self-checking bench for flash_bist.
// Instance dut uses default parameters with a 3-busy-cycle memory controller
// model; instance dut_w wraps the address space (BASE_ADDR=FFFF, LEN=300)
// against a controller that always returns 0xFF.
// -----------------------------------------------------------------------------
module tb_flash_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode  = 2'b00;
  logic        start_w = 1'b0;
  logic [1:0]  mode_w  = 2'b01;

  // Main instance wiring.
  logic        ctl_read, ctl_write, ctl_busy;
  logic [15:0] ctl_addr;
  logic [7:0]  ctl_din, ctl_dout;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_count;
  logic [2:0]  leds;

  // Wrap instance wiring.
  logic        ctl_read_w, ctl_write_w, ctl_busy_w;
  logic [15:0] ctl_addr_w;
  logic [7:0]  ctl_din_w, ctl_dout_w;
  logic        busy_w, done_w, pass_w, timeout_w;
  logic [7:0]  err_count_w;
  logic [2:0]  leds_w;

`ifdef FLASH_BIST_FIRST_FAIL_EN
  logic [15:0] ff_addr, ff_addr_w;
  logic [7:0]  ff_data, ff_data_w;
`endif

  flash_bist dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .ctl_read(ctl_read), .ctl_write(ctl_write), .ctl_addr(ctl_addr),
    .ctl_din(ctl_din), .ctl_dout(ctl_dout), .ctl_busy(ctl_busy),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .leds(leds)
`ifdef FLASH_BIST_FIRST_FAIL_EN
    , .first_fail_addr(ff_addr), .first_fail_data(ff_data)
`endif
  );

  flash_bist #(.BASE_ADDR(16'hFFFF), .LEN(300), .HOLD_CYCLES(3)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .mode(mode_w),
    .ctl_read(ctl_read_w), .ctl_write(ctl_write_w), .ctl_addr(ctl_addr_w),
    .ctl_din(ctl_din_w), .ctl_dout(ctl_dout_w), .ctl_busy(ctl_busy_w),
    .busy(busy_w), .done(done_w), .pass(pass_w), .timeout(timeout_w),
    .err_count(err_count_w), .leds(leds_w)
`ifdef FLASH_BIST_FIRST_FAIL_EN
    , .first_fail_addr(ff_addr_w), .first_fail_data(ff_data_w)
`endif
  );

  // Controller model for dut: memory, 3 busy cycles per command, optional
  // corruption of one address, and a log of issued commands.
  logic        busy_en = 1'b1;
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = 16'h0000;
  logic [1:0]  bcnt = 2'd0;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [15:0] rd_addr_q[$];

  assign ctl_busy = busy_en && (bcnt != 2'd0);
  assign ctl_dout = rd_data;

  always @(posedge clk) begin
    if (ctl_write || ctl_read) bcnt <= 2'd3;
    else if (bcnt != 2'd0)     bcnt <= bcnt - 2'd1;
    if (ctl_write) begin
      mem[ctl_addr] <= ctl_din;
      wr_addr_q.push_back(ctl_addr);
      wr_data_q.push_back(ctl_din);
    end
    if (ctl_read) begin
      rd_data <= (corrupt_en && (ctl_addr == corrupt_addr)) ? 8'h00 : mem[ctl_addr];
      rd_addr_q.push_back(ctl_addr);
    end
  end

  // Controller model for dut_w: one busy cycle, always reads 0xFF.
  logic        b_w = 1'b0;
  logic [15:0] rd_addr_w_q[$];
  assign ctl_busy_w = b_w;
  assign ctl_dout_w = 8'hFF;

  always @(posedge clk) begin
    b_w <= ctl_read_w || ctl_write_w;
    if (ctl_read_w) rd_addr_w_q.push_back(ctl_addr_w);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // Pulse start on dut and run until done; cycles counted from the cycle the
  // registered start is high (cycle n).
  task automatic go(input logic [1:0] m, input int max,
                    output int strobe_cyc, output int done_cyc);
    mode = m;
    start = 1'b1;
    step();
    start = 1'b0;
    strobe_cyc = -1;
    done_cyc = -1;
    for (int c = 1; c <= max; c++) begin
      step();
      if ((strobe_cyc < 0) && (ctl_read || ctl_write)) strobe_cyc = c;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check_eq("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle(input int max);
    for (int c = 0; c < max; c++) begin
      if (!busy) break;
      step();
    end
    check_eq("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  int s_cyc, d_cyc, nw;
  logic [15:0] ea;
  logic [7:0]  ed;

  initial begin
    // ---- reset state ----
    reset = 1'b1;
    step();
    check_eq("rst_leds",  {29'd0, leds}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_done",  {31'd0, done}, 32'd0);
    check_eq("rst_strobe", {30'd0, ctl_read, ctl_write}, 32'd0);
    check_eq("rst_err",   {24'd0, err_count}, 32'd0);
    check_eq("rst_addr",  {16'd0, ctl_addr}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check_eq("idle_leds", {29'd0, leds}, 32'd1);

    // ---- mode 00, 16 writes ----
    clear_logs();
    go(2'b00, 400, s_cyc, d_cyc);
    check_eq("m00_latency", s_cyc, 32'd2);
    check_eq("m00_cycles", d_cyc - s_cyc, 32'd96);
    check_eq("m00_pass", {31'd0, pass}, 32'd1);
    check_eq("m00_leds", {29'd0, leds}, 32'd4);
    check_eq("m00_err", {24'd0, err_count}, 32'd0);
    check_eq("m00_nwr", wr_addr_q.size(), 32'd16);
    check_eq("m00_nrd", rd_addr_q.size(), 32'd0);
    nw = wr_addr_q.size();
    for (int i = 0; i < 16; i++) begin
      ea = 16'h01AA + 16'(i);
      ed = 8'h55 + 8'(i);
      if (i < nw) begin
        check_eq("m00_wr_addr", {16'd0, wr_addr_q[i]}, {16'd0, ea});
        check_eq("m00_wr_data", {24'd0, wr_data_q[i]}, {24'd0, ed});
      end
    end
    // start edge during HOLD must be ignored
    mode = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_eq("hold_start_done", {31'd0, done}, 32'd1);
    wait_idle(400);
    repeat (5) step();
    check_eq("hold_start_busy", {31'd0, busy}, 32'd0);
    check_eq("hold_start_rd", rd_addr_q.size(), 32'd0);
    check_eq("idle_done", {31'd0, done}, 32'd0);
    check_eq("idle_leds2", {29'd0, leds}, 32'd1);

    // ---- mode 10, write then verify ----
    clear_logs();
    go(2'b10, 600, s_cyc, d_cyc);
    check_eq("m10_cycles", d_cyc - s_cyc, 32'd192);
    check_eq("m10_nwr", wr_addr_q.size(), 32'd16);
    check_eq("m10_nrd", rd_addr_q.size(), 32'd16);
    check_eq("m10_err", {24'd0, err_count}, 32'd0);
    check_eq("m10_pass", {31'd0, pass}, 32'd1);
    wait_idle(400);

    // ---- mode 01 with one corrupted word ----
    clear_logs();
    corrupt_en = 1'b1;
    corrupt_addr = 16'h01B0;
    go(2'b01, 400, s_cyc, d_cyc);
    check_eq("m01_nrd", rd_addr_q.size(), 32'd16);
    check_eq("m01_err", {24'd0, err_count}, 32'd1);
    check_eq("m01_pass", {31'd0, pass}, 32'd0);
`ifdef FLASH_BIST_FIRST_FAIL_EN
    check_eq("m01_ff_addr", {16'd0, ff_addr}, 32'h01B0);
    check_eq("m01_ff_data", {24'd0, ff_data}, 32'h00);
`endif
    wait_idle(400);
    corrupt_en = 1'b0;

    // ---- ctl_busy stuck low: timeout ----
    clear_logs();
    busy_en = 1'b0;
    go(2'b00, 100, s_cyc, d_cyc);
    check_eq("to_latency", s_cyc, 32'd2);
    check_eq("to_hold_cyc", d_cyc, 32'd18);
    check_eq("to_flag", {31'd0, timeout}, 32'd1);
    check_eq("to_pass", {31'd0, pass}, 32'd0);
    check_eq("to_leds", {29'd0, leds}, 32'd4);
    check_eq("to_nwr", wr_addr_q.size(), 32'd1);
    wait_idle(400);
    check_eq("to_sticky", {31'd0, timeout}, 32'd1);
    busy_en = 1'b1;

    // ---- reserved mode is dropped ----
    clear_logs();
    mode = 2'b11;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check_eq("m11_busy", {31'd0, busy}, 32'd0);
    check_eq("m11_leds", {29'd0, leds}, 32'd1);
    check_eq("m11_nwr", wr_addr_q.size() + rd_addr_q.size(), 32'd0);
    check_eq("m11_timeout_kept", {31'd0, timeout}, 32'd1);

    // ---- reset during WAIT ----
    mode = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ctl_write) break;
      step();
    end
    step();
    step();
    check_eq("wait_leds", {29'd0, leds}, 32'd2);
    check_eq("wait_timeout_clr", {31'd0, timeout}, 32'd0);
    reset = 1'b1;
    step();
    check_eq("rw_leds", {29'd0, leds}, 32'd0);
    check_eq("rw_strobe", {30'd0, ctl_read, ctl_write}, 32'd0);
    check_eq("rw_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();
    check_eq("rw_idle_leds", {29'd0, leds}, 32'd1);
    repeat (6) step();
    check_eq("rw_stays_idle", {31'd0, busy}, 32'd0);

    // ---- address wrap and error saturation on dut_w ----
    rd_addr_w_q.delete();
    mode_w = 2'b01;
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done_w) break;
      step();
    end
    check_eq("wrap_done", {31'd0, done_w}, 32'd1);
    check_eq("wrap_nrd", rd_addr_w_q.size(), 32'd300);
    if (rd_addr_w_q.size() >= 2) begin
      check_eq("wrap_addr0", {16'd0, rd_addr_w_q[0]}, 32'hFFFF);
      check_eq("wrap_addr1", {16'd0, rd_addr_w_q[1]}, 32'h0000);
    end
    check_eq("wrap_err_sat", {24'd0, err_count_w}, 32'd255);
    check_eq("wrap_pass", {31'd0, pass_w}, 32'd0);
`ifdef FLASH_BIST_FIRST_FAIL_EN
    check_eq("wrap_ff_addr", {16'd0, ff_addr_w}, 32'hFFFF);
    check_eq("wrap_ff_data", {24'd0, ff_data_w}, 32'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
